sd_cmd_responder: RTL

SD_CMD_RESPONDER -- requirements
Module: sd_cmd_responder

---
 rtl/sd_pkg.sv | 27 ++
 rtl/sd_crc7.sv | 36 +++
 rtl/sd_cmd_responder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: constants shared by the SD command-line responder.
// Token lengths, CRC7 polynomial, FSM encoding, R2 reserved field.
package sd_pkg;

   localparam int unsigned TOK_SHORT_LEN = 48;
   localparam int unsigned TOK_LONG_LEN  = 136;

   // x^7 + x^3 + 1, top term implicit
   localparam logic [6:0] CRC7_POLY = 7'h09;

   localparam logic [5:0] R2_RSVD = 6'b111111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RX   = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_TX   = 2'd3;

   function automatic logic [6:0] crc7_step(
      input logic [6:0] rem,
      input logic       din
   );
      logic fb;
      fb = din ^ rem[6];
      return {rem[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 remainder, one bit per enabled clock.
// Clear has priority over enable.
import sd_pkg::*;

module sd_crc7 (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic       din_i,
   output logic [6:0] crc_o
);

   logic [6:0] crc_q;
   logic [6:0] crc_d;

   // next remainder
   always_comb begin
      crc_d = crc_q;
      if (clr_i)
         crc_d = 7'd0;
      else if (en_i)
         crc_d = crc7_step(crc_q, din_i);
   end

   // remainder register, synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         crc_q <= 7'd0;
      else
         crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_responder.sv
// sd_cmd_responder: receives SD host commands, drives R1/R2 style responses.
// SD_CMD_CRC_CHECK_EN builds the receive CRC7 check; else only end bit is checked.
import sd_pkg::*;

module sd_cmd_responder #(
   parameter int NCR_CYCLES = 2
) (
   input  logic         sdClk,
   input  logic         sysRstN,
   input  logic         sdCmdIn,
   output logic         sdCmdOut,
   output logic         sdCmdEn,
   output logic         cmdValid,
   output logic [5:0]   cmdIndex,
   output logic [31:0]  cmdArg,
   output logic         cmdCrcErr,
   input  logic         rspReq,
   input  logic         rspLong,
   input  logic [5:0]   rspIndex,
   input  logic [31:0]  rspArg,
   input  logic [127:0] rspData,
   output logic         rspBusy,
   output logic         rspDone
);

   localparam logic [6:0] NCR = 7'(NCR_CYCLES);
   localparam logic [7:0] LAST_S = 8'(TOK_SHORT_LEN - 1);
   localparam logic [7:0] LAST_L = 8'(TOK_LONG_LEN - 1);

   logic [1:0]   state_q, state_d;
   logic [5:0]   rx_cnt_q, rx_cnt_d;
   logic [37:0]  rx_sr_q, rx_sr_d;
   logic [6:0]   wait_cnt_q, wait_cnt_d;
   logic [7:0]   tx_cnt_q, tx_cnt_d;
   logic         tx_long_q, tx_long_d;
   logic [119:0] tx_sr_q, tx_sr_d;
   logic         out_q, out_d;
   logic         en_q, en_d;
   logic         done_q, done_d;
   logic         valid_q, valid_d;
   logic [5:0]   idx_q, idx_d;
   logic [31:0]  arg_q, arg_d;
   logic         crc_err_q, crc_err_d;

   logic         rx_crc_bad;
   logic [6:0]   tx_crc;
   logic         tx_crc_clr;
   logic         tx_crc_en;
   logic         tx_bit;
   logic         tx_sh;
   logic [2:0]   tx_csel;
   logic [7:0]   tx_nxt;
   logic [7:0]   tx_last;
   logic         unused_rsp;

   // low byte of an R2 payload is replaced by CRC and end bit
   assign unused_rsp = ^rspData[7:0];

   assign tx_nxt  = tx_cnt_q + 8'd1;
   assign tx_last = tx_long_q ? LAST_L : LAST_S;

`ifdef SD_CMD_CRC_CHECK_EN
   logic [6:0] rx_crc;
   logic       rx_crc_clr;
   logic       rx_crc_en;

   // feeding the received CRC field too leaves zero on a match
   assign rx_crc_clr = (state_q != ST_RX);
   assign rx_crc_en  = (state_q == ST_RX) && (rx_cnt_q <= 6'd45);
   assign rx_crc_bad = (rx_crc != 7'd0);

   sd_crc7 u_rx_crc (
      .clk_i  (sdClk),
      .rst_ni (sysRstN),
      .clr_i  (rx_crc_clr),
      .en_i   (rx_crc_en),
      .din_i  (sdCmdIn),
      .crc_o  (rx_crc)
   );
`else
   assign rx_crc_bad = 1'b0;
`endif

   sd_crc7 u_tx_crc (
      .clk_i  (sdClk),
      .rst_ni (sysRstN),
      .clr_i  (tx_crc_clr),
      .en_i   (tx_crc_en && (state_q == ST_TX)),
      .din_i  (tx_bit),
      .crc_o  (tx_crc)
   );

   // select the response bit at position tx_nxt
   always_comb begin
      tx_bit    = 1'b1;
      tx_sh     = 1'b0;
      tx_crc_en = 1'b0;
      tx_csel   = 3'd0;
      if (tx_long_q) begin
         unique case (1'b1)
            (tx_nxt == 8'd1): tx_bit = 1'b0;
            (tx_nxt >= 8'd2 && tx_nxt <= 8'd7): begin
               tx_csel = 3'(8'd7 - tx_nxt);
               tx_bit  = R2_RSVD[tx_csel];
            end
            (tx_nxt >= 8'd8 && tx_nxt <= 8'd127): begin
               tx_bit    = tx_sr_q[119];
               tx_sh     = 1'b1;
               tx_crc_en = 1'b1;
            end
            (tx_nxt >= 8'd128 && tx_nxt <= 8'd134): begin
               tx_csel = 3'(8'd134 - tx_nxt);
               tx_bit  = tx_crc[tx_csel];
            end
            default: tx_bit = 1'b1;
         endcase
      end else begin
         unique case (1'b1)
            (tx_nxt == 8'd1): tx_bit = 1'b0;
            (tx_nxt >= 8'd2 && tx_nxt <= 8'd39): begin
               tx_bit    = tx_sr_q[119];
               tx_sh     = 1'b1;
               tx_crc_en = 1'b1;
            end
            (tx_nxt >= 8'd40 && tx_nxt <= 8'd46): begin
               tx_csel = 3'(8'd46 - tx_nxt);
               tx_bit  = tx_crc[tx_csel];
            end
            default: tx_bit = 1'b1;
         endcase
      end
   end

   // command/response state machine
   always_comb begin
      state_d    = state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_sr_d    = rx_sr_q;
      wait_cnt_d = wait_cnt_q;
      tx_cnt_d   = tx_cnt_q;
      tx_long_d  = tx_long_q;
      tx_sr_d    = tx_sr_q;
      out_d      = out_q;
      en_d       = en_q;
      done_d     = 1'b0;
      valid_d    = 1'b0;
      idx_d      = idx_q;
      arg_d      = arg_q;
      crc_err_d  = crc_err_q;
      tx_crc_clr = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!sdCmdIn) begin
               state_d  = ST_RX;
               rx_cnt_d = 6'd0;
            end
         end
         ST_RX: begin
            rx_cnt_d = rx_cnt_q + 6'd1;
            if (rx_cnt_q <= 6'd38)
               rx_sr_d = {rx_sr_q[36:0], sdCmdIn};
            if (rx_cnt_q == 6'd0 && !sdCmdIn) begin
               state_d = ST_IDLE;
            end else if (rx_cnt_q == 6'd46) begin
               state_d    = ST_WAIT;
               wait_cnt_d = 7'd0;
               valid_d    = 1'b1;
               idx_d      = rx_sr_q[37:32];
               arg_d      = rx_sr_q[31:0];
               crc_err_d  = !sdCmdIn || rx_crc_bad;
            end
         end
         ST_WAIT: begin
            if (!sdCmdIn) begin
               state_d  = ST_RX;
               rx_cnt_d = 6'd0;
            end else if (rspReq && wait_cnt_q == NCR) begin
               state_d    = ST_TX;
               tx_long_d  = rspLong;
               tx_sr_d    = rspLong ? rspData[127:8]
                                    : {rspIndex, rspArg, 82'd0};
               tx_cnt_d   = 8'd0;
               out_d      = 1'b0;
               en_d       = 1'b1;
               tx_crc_clr = 1'b1;
            end else if (wait_cnt_q != NCR) begin
               wait_cnt_d = wait_cnt_q + 7'd1;
            end
         end
         ST_TX: begin
            if (tx_cnt_q == tx_last) begin
               state_d = ST_IDLE;
               en_d    = 1'b0;
               out_d   = 1'b1;
               done_d  = 1'b1;
            end else begin
               tx_cnt_d = tx_nxt;
               out_d    = tx_bit;
               if (tx_sh)
                  tx_sr_d = {tx_sr_q[118:0], 1'b0};
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state registers, synchronous active-low reset releases the line
   always_ff @(posedge sdClk) begin
      if (!sysRstN) begin
         state_q    <= ST_IDLE;
         rx_cnt_q   <= 6'd0;
         rx_sr_q    <= 38'd0;
         wait_cnt_q <= 7'd0;
         tx_cnt_q   <= 8'd0;
         tx_long_q  <= 1'b0;
         tx_sr_q    <= 120'd0;
         out_q      <= 1'b1;
         en_q       <= 1'b0;
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
         idx_q      <= 6'd0;
         arg_q      <= 32'd0;
         crc_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_sr_q    <= rx_sr_d;
         wait_cnt_q <= wait_cnt_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_long_q  <= tx_long_d;
         tx_sr_q    <= tx_sr_d;
         out_q      <= out_d;
         en_q       <= en_d;
         done_q     <= done_d;
         valid_q    <= valid_d;
         idx_q      <= idx_d;
         arg_q      <= arg_d;
         crc_err_q  <= crc_err_d;
      end
   end

   assign sdCmdOut  = out_q;
   assign sdCmdEn   = en_q;
   assign rspBusy   = en_q;
   assign rspDone   = done_q;
   assign cmdValid  = valid_q;
   assign cmdIndex  = idx_q;
   assign cmdArg    = arg_q;
   assign cmdCrcErr = crc_err_q;

endmodule
